// File: rtl/pio_in_edge_24.sv
// pio_in_edge_24: Avalon-MM input port with per-bit synchroniser, glitch filter,
// sticky edge capture and a maskable level interrupt.
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   address         0=filtered data, 1=zero, 2=irqmask, 3=edgecapture (W1C)
//   chipselect      slave select, qualifies writes only
//   write_n         active-low write strobe
//   writedata       write data
//   in_port         asynchronous external pins
//   readdata        combinational read data
//   irq             registered level interrupt
module pio_in_edge_24 #(
   parameter int WIDTH         = 1,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int EDGE_TYPE     = 2,
   parameter bit INIT_LEVEL    = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);
   localparam int CW = $clog2(FILTER_CYCLES) + 1;
   localparam logic [WIDTH-1:0] INIT = {WIDTH{INIT_LEVEL}};
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] smp_q, filt_q, filt_d, mask_q, mask_d, cap_q, cap_d;
   logic [WIDTH-1:0] rise, fall, edge_w, clr;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic             wr, irq_q;
   assign wr = chipselect & ~write_n;
   // smp_q retimes the synchroniser output once more, so a pin change seen by the
   // first stage on edge 0 reaches filt on edge SYNC_STAGES+FILTER_CYCLES while the
   // filter still needs FILTER_CYCLES consecutive mismatching samples.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (smp_q[i] != filt_q[i]) begin
            if (cnt_q[i] == CW'(FILTER_CYCLES - 1)) filt_d[i] = smp_q[i];
            else cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end
   assign rise   = filt_d & ~filt_q;
   assign fall   = ~filt_d & filt_q;
   assign edge_w = EDGE_TYPE == 0 ? rise : EDGE_TYPE == 1 ? fall : rise | fall;
   assign clr    = (wr && address == 2'd3) ? writedata : '0;
   // a new edge overrides a clear of the same bit
   assign cap_d  = (cap_q & ~clr) | edge_w;
   assign mask_d = (wr && address == 2'd2) ? writedata : mask_q;
   assign readdata = address == 2'd0 ? filt_q :
                     address == 2'd2 ? mask_q :
                     address == 2'd3 ? cap_q  : '0;
   assign irq = irq_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= INIT;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
         smp_q  <= INIT;
         filt_q <= INIT;
         mask_q <= '0;
         cap_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         sync_q[0] <= in_port;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
         smp_q  <= sync_q[SYNC_STAGES-1];
         filt_q <= filt_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
         irq_q  <= |(cap_q & mask_q);
      end
   end
endmodule

// File: tb/tb_pio_in_edge_24.sv
// tb_pio_in_edge_24: randomized and directed check of pio_in_edge_24 against a
// behavioural model (delay line + consecutive-sample window filter).
//   u_a: WIDTH=1, any-edge capture (defaults); u_b: WIDTH=4, rising-edge capture.
module tb_pio_in_edge_24;
   localparam int S = 2, F = 4;
   logic       clk = 1'b0, reset;
   logic [1:0] address;
   logic       chipselect, write_n;
   logic [3:0] writedata, pins;
   logic [0:0] rd_a;
   logic [3:0] rd_b;
   logic       irq_a, irq_b;
   int         n_tests = 0, n_fail = 0;
   logic [3:0] m_filt [2], m_cap [2], m_mask [2];
   logic       m_irq [2];
   logic [3:0] m_pipe [2][S+1];
   logic [3:0] m_win  [2][F];
   always #10 clk = ~clk;
   pio_in_edge_24 u_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata[0:0]), .in_port(pins[0:0]),
      .readdata(rd_a), .irq(irq_a));
   pio_in_edge_24 #(.WIDTH(4), .EDGE_TYPE(0)) u_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(pins),
      .readdata(rd_b), .irq(irq_b));
   function automatic logic [3:0] wm(input int d);
      return d == 0 ? 4'h1 : 4'hF;
   endfunction
   function automatic int et(input int d);
      return d == 0 ? 2 : 0;
   endfunction
   function automatic logic [3:0] m_rd(input int d, input logic [1:0] a);
      return a == 2'd0 ? m_filt[d] : a == 2'd2 ? m_mask[d] : a == 2'd3 ? m_cap[d] : 4'h0;
   endfunction
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask
   task automatic m_reset();
      for (int d = 0; d < 2; d++) begin
         m_filt[d] = wm(d); m_cap[d] = 4'h0; m_mask[d] = 4'h0; m_irq[d] = 1'b0;
         for (int k = 0; k <= S; k++) m_pipe[d][k] = wm(d);
         for (int k = 0; k < F; k++) m_win[d][k] = wm(d);
      end
   endtask
   // one clock edge: the filter sees the pin value from S+1 edges ago and a bit
   // follows once its last F filter samples all disagree with the current level
   task automatic m_step(input logic wr, input logic [1:0] ad, input logic [3:0] wd,
                         input logic [3:0] pin);
      for (int d = 0; d < 2; d++) begin
         logic [3:0] fin, flip, nf, ev, clr;
         logic       irq_n;
         fin = m_pipe[d][0];
         for (int k = 0; k < S; k++) m_pipe[d][k] = m_pipe[d][k+1];
         m_pipe[d][S] = pin & wm(d);
         for (int k = 0; k < F - 1; k++) m_win[d][k] = m_win[d][k+1];
         m_win[d][F-1] = fin;
         flip = wm(d);
         for (int k = 0; k < F; k++) flip &= m_win[d][k] ^ m_filt[d];
         nf = m_filt[d] ^ flip;
         ev = et(d) == 0 ? (flip & nf) : et(d) == 1 ? (flip & ~nf) : flip;
         irq_n = |(m_cap[d] & m_mask[d]);
         clr = (wr && ad == 2'd3) ? (wd & wm(d)) : 4'h0;
         m_cap[d] = (m_cap[d] & ~clr) | ev;
         if (wr && ad == 2'd2) m_mask[d] = wd & wm(d);
         m_filt[d] = nf;
         m_irq[d] = irq_n;
      end
   endtask
   task automatic check_all();
      for (int a = 0; a < 4; a++) begin
         address = 2'(a); chipselect = 1'b0; write_n = 1'b1; #1;
         chk($sformatf("a_rd%0d", a), 32'(rd_a), 32'(m_rd(0, 2'(a))));
         chk($sformatf("b_rd%0d", a), 32'(rd_b), 32'(m_rd(1, 2'(a))));
      end
      chk("a_irq", 32'(irq_a), 32'(m_irq[0]));
      chk("b_irq", 32'(irq_b), 32'(m_irq[1]));
   endtask
   task automatic cycle(input logic cs, input logic wn, input logic [1:0] ad,
                        input logic [3:0] wd, input logic [3:0] pin);
      check_all();
      chipselect = cs; write_n = wn; address = ad; writedata = wd; pins = pin;
      m_step(cs && !wn, ad, wd, pin);
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic idle(input int n, input logic [3:0] pin);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b1, 2'd0, 4'h0, pin);
   endtask
   task automatic peek(input logic [1:0] ad);
      address = ad; chipselect = 1'b0; write_n = 1'b1; #1;
   endtask
   task automatic do_reset();
      reset = 1'b1; #1;
      m_reset();
      check_all();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask
   initial begin
      int lat, irq_lat;
      logic [3:0] p;
      reset = 1'b1; pins = 4'hF; address = 2'd0; chipselect = 1'b0;
      write_n = 1'b1; writedata = 4'h0;
      m_reset();
      @(negedge clk);
      check_all();
      peek(2'd0); chk("rst_data", 32'(rd_a), 32'h1);
      peek(2'd3); chk("rst_cap", 32'(rd_a), 32'h0);
      reset = 1'b0;
      idle(4, 4'hF);
      cycle(1'b1, 1'b0, 2'd2, 4'hF, 4'hF);
      lat = -1; irq_lat = -1;
      for (int k = 0; k < 20; k++) begin
         cycle(1'b0, 1'b1, 2'd0, 4'h0, 4'h0);
         peek(2'd0);
         if (lat < 0 && rd_a == 1'b0) lat = k;
         if (irq_lat < 0 && irq_a) irq_lat = k;
      end
      chk("latency_filt", 32'(lat), 32'd6);
      chk("latency_irq", 32'(irq_lat), 32'd7);
      idle(12, 4'hF);
      cycle(1'b1, 1'b0, 2'd3, 4'h0, 4'hF);
      peek(2'd3); chk("w0_keeps_cap", 32'(rd_a), 32'h1);
      cycle(1'b1, 1'b0, 2'd3, 4'hF, 4'hF);
      peek(2'd3); chk("clr_cap", 32'(rd_a), 32'h0);
      chk("clr_irq_lag", 32'(irq_a), 32'h1);
      idle(1, 4'hF);
      chk("clr_irq", 32'(irq_a), 32'h0);
      idle(3, 4'h0);
      idle(12, 4'hF);
      peek(2'd0); chk("glitch3_data", 32'(rd_a), 32'h1);
      peek(2'd3); chk("glitch3_cap", 32'(rd_a), 32'h0);
      chk("glitch3_irq", 32'(irq_a), 32'h0);
      idle(4, 4'h0);
      idle(12, 4'hF);
      peek(2'd3); chk("glitch4_cap", 32'(rd_a), 32'h1);
      idle(6, 4'h0);
      cycle(1'b1, 1'b0, 2'd3, 4'hF, 4'h0);
      peek(2'd3); chk("collision_cap", 32'(rd_a), 32'h1);
      idle(12, 4'hF);
      do_reset();
      p = 4'hF;
      for (int n = 0; n < 900; n++) begin
         if ($urandom_range(0, 3) == 0) p ^= 4'($urandom_range(0, 15));
         if (n % 300 == 299) do_reset();
         cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), p);
      end
      check_all();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
